// File: rtl/rtc_scan_control.sv
// Reads NUM_REG RTC registers (0x21..0x26) per scan through the write/read sequencer,
// with a per-transfer watchdog. Define RTC_SCAN_CONT_EN for back-to-back continuous scanning.
//
// state | meaning
// IDLE  | waiting for Start
// ISSUE | one-cycle ciclo pulse to the sequencer
// WAIT  | watching Sent_D fall / Fin, watchdog counting down
// STORE | capture register copied to the indexed output
// NEXT  | advance index or finish
// DONE  | one-cycle Listo pulse
module rtc_scan_control #(
    parameter int          NUM_REG = 6,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic       Clock_in,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Fin,
    input  logic       Sent_D,
    input  logic [7:0] Dato_in,
    output logic       ciclo,
    output logic [7:0] Direccion,
    output logic [7:0] Seg,
    output logic [7:0] Min,
    output logic [7:0] Hora,
    output logic [7:0] Dia,
    output logic [7:0] Mes,
    output logic [7:0] Anio,
    output logic       Ocupado,
    output logic       Listo,
    output logic       Error
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, NEXT, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  idx;
    logic [15:0] wdog;
    logic        sent_d_q;
    logic [7:0]  cap;
    logic        sent_d_fall;
    logic        last_reg;

    assign sent_d_fall = sent_d_q & ~Sent_D;
    assign last_reg    = (idx >= 3'(NUM_REG - 1));
    assign Direccion   = 8'h21 + 8'(idx);

    always_comb begin
        state_nxt = state;
        ciclo     = 1'b0;
        Listo     = 1'b0;
        Ocupado   = (state != IDLE);
        case (state)
            IDLE:  if (Start) state_nxt = ISSUE;
            ISSUE: begin
                ciclo     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (Fin)              state_nxt = STORE;
                else if (wdog == '0)  state_nxt = IDLE;
            end
            STORE: state_nxt = NEXT;
            NEXT:  state_nxt = last_reg ? DONE : ISSUE;
            DONE: begin
                Listo = 1'b1;
`ifdef RTC_SCAN_CONT_EN
                state_nxt = ISSUE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            state    <= IDLE;
            idx      <= '0;
            wdog     <= '0;
            sent_d_q <= 1'b0;
            cap      <= '0;
            Error    <= 1'b0;
            Seg      <= '0;
            Min      <= '0;
            Hora     <= '0;
            Dia      <= '0;
            Mes      <= '0;
            Anio     <= '0;
        end else begin
            state    <= state_nxt;
            sent_d_q <= Sent_D;
            case (state)
                IDLE: begin
                    if (Start) begin
                        idx   <= '0;
                        Error <= 1'b0;
                        wdog  <= '0;
                    end
                end
                ISSUE: wdog <= TIMEOUT - 16'd1;
                WAIT: begin
                    // Fall and Fin in the same cycle still capture this cycle's byte
                    if (sent_d_fall) cap <= Dato_in;
                    if (!Fin) begin
                        if (wdog == '0) Error <= 1'b1;
                        else            wdog  <= wdog - 16'd1;
                    end
                end
                STORE: begin
                    case (idx)
                        3'd0:    Seg  <= cap;
                        3'd1:    Min  <= cap;
                        3'd2:    Hora <= cap;
                        3'd3:    Dia  <= cap;
                        3'd4:    Mes  <= cap;
                        3'd5:    Anio <= cap;
                        default: ;
                    endcase
                end
                NEXT: if (!last_reg) idx <= idx + 3'd1;
                DONE: idx <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_scan_control.sv
// Self-checking bench for rtc_scan_control: table-driven scans against a sequencer model,
// plus timeout and mid-scan reset sequences.
module tb_rtc_scan_control;

    logic Clock_in = 1'b0;
    always #5 Clock_in = ~Clock_in;

    logic       Reset, Start, Start_b, Fin, Sent_D;
    logic [7:0] Dato_in;

    logic       ciclo_a, ocu_a, listo_a, err_a;
    logic [7:0] dir_a, seg_a, min_a, hora_a, dia_a, mes_a, anio_a;
    logic       ciclo_b, ocu_b, listo_b, err_b;
    logic [7:0] dir_b, seg_b, min_b, hora_b, dia_b, mes_b, anio_b;

    rtc_scan_control #(.NUM_REG(6), .TIMEOUT(16'd100)) dut_a (
        .Clock_in(Clock_in), .Reset(Reset), .Start(Start), .Fin(Fin), .Sent_D(Sent_D),
        .Dato_in(Dato_in), .ciclo(ciclo_a), .Direccion(dir_a), .Seg(seg_a), .Min(min_a),
        .Hora(hora_a), .Dia(dia_a), .Mes(mes_a), .Anio(anio_a), .Ocupado(ocu_a),
        .Listo(listo_a), .Error(err_a));

    rtc_scan_control #(.NUM_REG(3)) dut_b (
        .Clock_in(Clock_in), .Reset(Reset), .Start(Start_b), .Fin(Fin), .Sent_D(Sent_D),
        .Dato_in(Dato_in), .ciclo(ciclo_b), .Direccion(dir_b), .Seg(seg_b), .Min(min_b),
        .Hora(hora_b), .Dia(dia_b), .Mes(mes_b), .Anio(anio_b), .Ocupado(ocu_b),
        .Listo(listo_b), .Error(err_b));

    wire [47:0] vals_a = {seg_a, min_a, hora_a, dia_a, mes_a, anio_a};
    wire [47:0] vals_b = {seg_b, min_b, hora_b, dia_b, mes_b, anio_b};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // mode 0: Sent_D falls, Fin two cycles later; 1: fall coincides with Fin; 2: Fin only
    typedef struct {
        logic [47:0] data;
        int          mode;
        bit          restart;
        logic [47:0] exp;
    } vec_t;
    vec_t vecs[4];

    logic [7:0] byte_q[$];
    logic [7:0] addr_q[$];
    int         seq_mode = 0;

    int cic_cnt = 0, cic_b_cnt = 0, listo_cnt = 0, listo_b_cnt = 0;

    // Sequencer model: answers each ciclo of dut_a while bytes are queued
    initial begin
        logic [7:0] b;
        Sent_D  = 1'b0;
        Fin     = 1'b0;
        Dato_in = 8'hA5;
        forever begin
            @(negedge Clock_in);
            if (ciclo_a === 1'b1 && byte_q.size() > 0) begin
                b = byte_q.pop_front();
                @(negedge Clock_in);
                if (seq_mode == 2) begin
                    Fin = 1'b1;
                    @(negedge Clock_in);
                    Fin = 1'b0;
                end else begin
                    Sent_D  = 1'b1;
                    Dato_in = b;
                    repeat (2) @(negedge Clock_in);
                    Sent_D = 1'b0;
                    if (seq_mode == 1) begin
                        Fin = 1'b1;
                        @(negedge Clock_in);
                        Fin     = 1'b0;
                        Dato_in = 8'hA5;
                    end else begin
                        @(negedge Clock_in);
                        Dato_in = 8'hA5;
                        @(negedge Clock_in);
                        Fin = 1'b1;
                        @(negedge Clock_in);
                        Fin = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard: each ciclo pops the address expected for that transfer
    always @(negedge Clock_in) begin
        if (ciclo_a === 1'b1) begin
            cic_cnt++;
            if (addr_q.size() == 0) check("ciclo_unexpected", 64'(1), 64'(0));
            else                    check("direccion", 64'(dir_a), 64'(addr_q.pop_front()));
        end
        if (ciclo_b === 1'b1) cic_b_cnt++;
        if (listo_a === 1'b1) listo_cnt++;
        if (listo_b === 1'b1) listo_b_cnt++;
    end

    initial begin
        int  c0, l0, cb0, lb0;
        bit  got;

        vecs[0] = '{data: 48'h45_30_12_07_04_16, mode: 0, restart: 1'b0, exp: 48'h45_30_12_07_04_16};
        vecs[1] = '{data: 48'h59_11_22_33_44_55, mode: 1, restart: 1'b1, exp: 48'h59_11_22_33_44_55};
        vecs[2] = '{data: 48'h01_02_03_04_05_06, mode: 2, restart: 1'b0, exp: 48'h55_55_55_55_55_55};
        vecs[3] = '{data: 48'h00_59_23_31_12_99, mode: 0, restart: 1'b0, exp: 48'h00_59_23_31_12_99};

        Reset   = 1'b1;
        Start   = 1'b0;
        Start_b = 1'b0;
        repeat (3) @(negedge Clock_in);
        check("rst_vals",    64'(vals_a),  64'(0));
        check("rst_dir",     64'(dir_a),   64'(8'h21));
        check("rst_ocupado", 64'(ocu_a),   64'(0));
        check("rst_error",   64'(err_a),   64'(0));
        check("rst_ciclo",   64'(ciclo_a), 64'(0));
        check("rst_listo",   64'(listo_a), 64'(0));
        check("rst_vals_b",  64'(vals_b),  64'(0));
        Reset = 1'b0;
        @(negedge Clock_in);

        for (int v = 0; v < 4; v++) begin
            seq_mode = vecs[v].mode;
            for (int i = 0; i < 6; i++) begin
                byte_q.push_back(vecs[v].data[47 - 8*i -: 8]);
                addr_q.push_back(8'h21 + 8'(i));
            end
`ifdef RTC_SCAN_CONT_EN
            addr_q.push_back(8'h21);
`endif
            c0 = cic_cnt; l0 = listo_cnt; cb0 = cic_b_cnt; lb0 = listo_b_cnt;
            Start = 1'b1;
            if (v == 0) Start_b = 1'b1;
            @(negedge Clock_in);
            Start   = 1'b0;
            Start_b = 1'b0;
            check("ocupado_busy", 64'(ocu_a), 64'(1));
            got = 1'b0;
            for (int c = 0; c < 600 && !got; c++) begin
                Start = (vecs[v].restart && c == 8);
                @(negedge Clock_in);
                if (listo_a === 1'b1) got = 1'b1;
            end
            Start = 1'b0;
            check("listo_seen", 64'(got),            64'(1));
            check("scan_vals",  64'(vals_a),         64'(vecs[v].exp));
            check("ciclo_cnt",  64'(cic_cnt - c0),   64'(6));
            check("no_error",   64'(err_a),          64'(0));
            if (v == 0) begin
                check("b_vals",   64'(vals_b),            64'(48'h45_30_12_00_00_00));
                check("b_ciclo",  64'(cic_b_cnt - cb0),   64'(3));
                check("b_listo",  64'(listo_b_cnt - lb0), 64'(1));
            end
`ifdef RTC_SCAN_CONT_EN
            @(negedge Clock_in);
            check("cont_reissue", 64'(ciclo_a), 64'(1));
            repeat (105) @(negedge Clock_in);
            check("cont_timeout_idle", 64'(ocu_a), 64'(0));
`else
            @(negedge Clock_in);
            check("idle_after_done", 64'(ocu_a),           64'(0));
            check("listo_once",      64'(listo_cnt - l0),  64'(1));
            repeat (10) @(negedge Clock_in);
            check("no_extra_ciclo",  64'(cic_cnt - c0),    64'(6));
            check("still_idle",      64'(ocu_a),           64'(0));
`endif
        end

        // Watchdog: no sequencer response, WAIT lasts exactly 100 cycles
        addr_q.push_back(8'h21);
        l0 = listo_cnt;
        Start = 1'b1;
        @(negedge Clock_in);
        Start = 1'b0;
        check("to_ciclo", 64'(ciclo_a), 64'(1));
        repeat (100) @(negedge Clock_in);
        check("to_err_early", 64'(err_a), 64'(0));
        check("to_busy",      64'(ocu_a), 64'(1));
        @(negedge Clock_in);
        check("to_error",     64'(err_a),           64'(1));
        check("to_idle",      64'(ocu_a),           64'(0));
        check("to_no_listo",  64'(listo_cnt - l0),  64'(0));
        check("to_keep_vals", 64'(vals_a),          64'(vecs[3].exp));

        // Reset during the 3rd transfer
        seq_mode = 0;
        for (int i = 0; i < 6; i++) begin
            byte_q.push_back(8'h81 + 8'(i));
            addr_q.push_back(8'h21 + 8'(i));
        end
        c0 = cic_cnt; l0 = listo_cnt;
        Start = 1'b1;
        @(negedge Clock_in);
        Start = 1'b0;
        check("err_clear_on_start", 64'(err_a), 64'(0));
        for (int c = 0; c < 400 && (cic_cnt - c0) < 3; c++) @(negedge Clock_in);
        check("reached_third", 64'(cic_cnt - c0), 64'(3));
        repeat (3) @(negedge Clock_in);
        Reset = 1'b1;
        repeat (2) @(negedge Clock_in);
        Reset = 1'b0;
        check("mid_rst_vals",    64'(vals_a), 64'(0));
        check("mid_rst_ocupado", 64'(ocu_a),  64'(0));
        check("mid_rst_dir",     64'(dir_a),  64'(8'h21));
        check("mid_rst_error",   64'(err_a),  64'(0));
        byte_q.delete();
        addr_q.delete();
        c0 = cic_cnt;
        repeat (40) @(negedge Clock_in);
        check("post_rst_no_ciclo", 64'(cic_cnt - c0),   64'(0));
        check("post_rst_no_listo", 64'(listo_cnt - l0), 64'(0));
        check("post_rst_vals",     64'(vals_a),         64'(0));
        check("post_rst_idle",     64'(ocu_a),          64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_scan_control.md
RTC_SCAN_CONTROL -- requirements
Module: rtc_scan_control

Interface
- REQ-001: Parameter NUM_REG, default 6, number of RTC registers read per scan (range 1..6).
- REQ-002: Parameter TIMEOUT, default 16'hFFFF, Clock_in cycles allowed per transfer before abort.
- REQ-003: Clock_in  input  1  system clock, 100 MHz, all logic on rising edge.
- REQ-004: Reset  input  1  synchronous, active-high.
- REQ-005: Start  input  1  one-cycle request to begin one scan.
- REQ-006: Fin  input  1  end-of-transfer pulse from the write/read sequencer.
- REQ-007: Sent_D  input  1  sequencer read-data window; high while bus data is valid.
- REQ-008: Dato_in  input  8  data byte from the multiplexed RTC bus.
- REQ-009: ciclo  output  1  one-cycle start pulse to the write/read sequencer.
- REQ-010: Direccion  output  8  RTC register address for the current transfer.
- REQ-011: Seg, Min, Hora, Dia, Mes, Anio  output  8 each  captured RTC register values.
- REQ-012: Ocupado  output  1  high while a scan is in progress.
- REQ-013: Listo  output  1  one-cycle pulse when a scan completes.
- REQ-014: Error  output  1  sticky timeout flag.

Function
- REQ-015: FSM states SHALL be IDLE, ISSUE, WAIT, STORE, NEXT, DONE.
- REQ-016: IDLE -> ISSUE when Start=1; index SHALL clear to 0, Error SHALL clear, watchdog SHALL clear.
- REQ-017: ISSUE SHALL assert ciclo for exactly one cycle, then go to WAIT.
- REQ-018: Direccion SHALL be 8'h21,22,23,24,25,26 for index 0..5, stable from ISSUE through STORE.
- REQ-019: A Sent_D falling edge (registered previous value 1, current 0) in WAIT SHALL load Dato_in of that same cycle into an 8-bit capture register.
- REQ-020: WAIT -> STORE on Fin=1; if the Sent_D fall and Fin coincide, the captured byte SHALL be that cycle's Dato_in.
- REQ-021: STORE SHALL write the capture register to the output selected by index (0 Seg, 1 Min, 2 Hora, 3 Dia, 4 Mes, 5 Anio) in one cycle.
- REQ-022: NEXT SHALL go to ISSUE with index+1 if index < NUM_REG-1, else to DONE.
- REQ-023: DONE SHALL pulse Listo for one cycle and return to IDLE.
- REQ-024: Ocupado SHALL be 1 in every state except IDLE.
- REQ-025: Start while Ocupado=1 SHALL be ignored.
- REQ-026: The watchdog SHALL count cycles in WAIT; reaching TIMEOUT SHALL set Error, leave outputs unchanged, and return to IDLE without Listo.
- REQ-027: Fin without a preceding Sent_D fall SHALL store the previous capture-register contents.
- REQ-028: Outputs for indices >= NUM_REG SHALL keep their values.
- REQ-029: Fin or Sent_D activity outside WAIT SHALL be ignored.

Reset
- REQ-030: Reset SHALL force IDLE, index 0, ciclo 0, Listo 0, Ocupado 0, Error 0, Direccion 8'h21, capture register and all six value outputs 8'h00.
- REQ-031: Reset mid-scan SHALL abort with no Listo and no further ciclo pulse.

Configuration
- REQ-032: Macro RTC_SCAN_CONT_EN defined: DONE SHALL go directly to ISSUE with index 0 (continuous scanning; Listo still pulses each scan; timeout still returns to IDLE).
- REQ-033: Macro RTC_SCAN_CONT_EN undefined: DONE SHALL return to IDLE and wait for Start.

Verification
- REQ-034: Start, sequencer model returning 8'h45,30,12,07,04,16 -> Seg..Anio = 45,30,12,07,04,16; six ciclo pulses; Listo once.
- REQ-035: NUM_REG=3, same stimulus -> Seg/Min/Hora loaded; Dia/Mes/Anio stay 8'h00; three ciclo pulses.
- REQ-036: TIMEOUT=100, Fin never asserted -> Error=1 at cycle 100 of WAIT; IDLE; Listo never pulses.
- REQ-037: Reset asserted during the 3rd transfer -> all outputs 8'h00, Ocupado=0, no further ciclo.
- REQ-038: Start pulsed during scan, and Sent_D fall coincident with Fin carrying 8'h59 -> second Start ignored; byte 8'h59 stored.
- REQ-039: RTC_SCAN_CONT_EN defined -> ciclo for index 0 issued one cycle after each Listo, indefinitely.
